// File: rtl/cache_sa_ctrl.sv
// Set-associative write-through, no-write-allocate cache with miss-fill FSM,
// true-LRU age replacement, flush and saturating hit/miss counters.
module cache_sa_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WAYS   = 2,
    parameter int SETS   = 64,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              stall,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int SET_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - SET_W - OFF_W - 1;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, FILL, WMEM} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] data_q  [WAYS][SETS][WORDS];
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic              valid_q [WAYS][SETS];
    logic [WAY_W-1:0]  age_q   [WAYS][SETS];

    logic [OFF_W-1:0]  req_off;
    logic [SET_W-1:0]  req_set;
    logic [TAG_W-1:0]  req_tag;

    logic [TAG_W-1:0]  fill_tag;
    logic [SET_W-1:0]  fill_set;
    logic [OFF_W-1:0]  fill_k;
    logic [WAY_W-1:0]  victim_q;

    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              wr_hit_q;
    logic [WAY_W-1:0]  wr_way_q;
    logic [SET_W-1:0]  wr_set;
    logic [OFF_W-1:0]  wr_off;

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim;
    logic              found_inv;

    logic do_flush, load_hit, load_miss, store_req;
    logic fill_ack, fill_last, wr_ack, wr_store_en;
    logic touch_en;
    logic [WAY_W-1:0] touch_way;
    logic [SET_W-1:0] touch_set;

    assign req_off = req_addr[OFF_W:1];
    assign req_set = req_addr[OFF_W+SET_W:OFF_W+1];
    assign req_tag = req_addr[ADDR_W-1:OFF_W+SET_W+1];
    assign wr_off  = wr_addr_q[OFF_W:1];
    assign wr_set  = wr_addr_q[OFF_W+SET_W:OFF_W+1];
    assign stall   = req_valid & ~resp_valid;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[w][req_set] && tag_q[w][req_set] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Oldest way is the fallback; any invalid way (lowest index) overrides it.
    always_comb begin
        victim    = '0;
        found_inv = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (age_q[w][req_set] == WAY_W'(WAYS - 1))
                victim = WAY_W'(w);
        end
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!found_inv && !valid_q[w][req_set]) begin
                victim    = WAY_W'(w);
                found_inv = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        resp_valid = 1'b0;
        resp_rdata = '0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        do_flush   = 1'b0;
        load_hit   = 1'b0;
        load_miss  = 1'b0;
        store_req  = 1'b0;
        fill_ack   = 1'b0;
        fill_last  = 1'b0;
        wr_ack     = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    do_flush = 1'b1;
                end else if (req_valid) begin
                    if (req_write) begin
                        store_req = 1'b1;
                        state_d   = WMEM;
                    end else if (hit) begin
                        load_hit   = 1'b1;
                        resp_valid = 1'b1;
                        resp_rdata = data_q[hit_way][req_set][req_off];
                    end else begin
                        load_miss = 1'b1;
                        state_d   = FILL;
                    end
                end
            end
            FILL: begin
                mem_rd   = 1'b1;
                mem_addr = {fill_tag, fill_set, fill_k, 1'b0};
                if (mem_ack) begin
                    fill_ack = 1'b1;
                    if (&fill_k) begin
                        fill_last = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            WMEM: begin
                mem_wr    = 1'b1;
                mem_addr  = wr_addr_q;
                mem_wdata = wr_data_q;
                if (mem_ack) begin
                    wr_ack     = 1'b1;
                    resp_valid = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_store_en = wr_ack & wr_hit_q & valid_q[wr_way_q][wr_set];
        touch_en    = load_hit | fill_last | wr_store_en;
        touch_way   = load_hit ? hit_way : (fill_last ? victim_q : wr_way_q);
        touch_set   = load_hit ? req_set : (fill_last ? fill_set : wr_set);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fill_tag   <= '0;
            fill_set   <= '0;
            fill_k     <= '0;
            victim_q   <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_hit_q   <= 1'b0;
            wr_way_q   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            for (int unsigned w = 0; w < WAYS; w++) begin
                for (int unsigned s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    age_q[w][s]   <= WAY_W'(w);
                end
            end
        end else begin
            state_q <= state_d;
            if (do_flush) begin
                for (int unsigned w = 0; w < WAYS; w++)
                    for (int unsigned s = 0; s < SETS; s++)
                        valid_q[w][s] <= 1'b0;
            end
            if (load_miss) begin
                fill_tag <= req_tag;
                fill_set <= req_set;
                fill_k   <= '0;
                victim_q <= victim;
            end
            if (fill_ack)
                fill_k <= fill_k + 1'b1;
            if (fill_last)
                valid_q[victim_q][fill_set] <= 1'b1;
            if (store_req) begin
                wr_addr_q <= req_addr;
                wr_data_q <= req_wdata;
                wr_hit_q  <= hit;
                wr_way_q  <= hit_way;
            end
            // Ages younger than the touched way shift up; touched way becomes 0.
            if (touch_en) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (age_q[w][touch_set] < age_q[touch_way][touch_set])
                        age_q[w][touch_set] <= age_q[w][touch_set] + 1'b1;
                end
                age_q[touch_way][touch_set] <= '0;
            end
            if ((load_hit || (store_req && hit)) && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (load_miss && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_ack)
            data_q[victim_q][fill_set][fill_k] <= mem_rdata;
        if (fill_last)
            tag_q[victim_q][fill_set] <= fill_tag;
        if (wr_store_en)
            data_q[wr_way_q][wr_set][wr_off] <= wr_data_q;
    end

endmodule
